// File: rtl/centroid_div_sched.sv
// rtl/centroid_div_sched.sv - centroid scheduler sharing one divider between x and y
//
// Purpose: on each end-of-frame, divides the x and y moments by the frame area
// using a single external divider, then publishes x/y together with a valid
// pulse. A one-deep pending slot absorbs an end-of-frame that arrives while a
// frame is still being divided; if that slot is already full, the older pending
// frame is dropped and overrun pulses.
//
// Optional feature: define CENTROID_DIV_WATCHDOG_EN to abort a division that
// has not returned div_qv within TMO cycles (err pulses, state returns to IDLE,
// pending slot is kept). Without it the block waits for div_qv indefinitely and
// err is tied low.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   eof, m_00/01/10     end-of-frame pulse and that frame's area / x / y moments
//   div_start           one-cycle start strobe to the shared divider
//   div_dividend/divisor operands, stable while the divider is busy
//   div_quotient/qv     divider result and its valid pulse
//   x, y, valid         centroid coordinates and their one-cycle update pulse
//   empty               last published frame had area 0
//   overrun             one-cycle pulse when a pending frame is dropped
//   err                 one-cycle pulse on divider timeout
module centroid_div_sched #(
  parameter int DW  = 32,
  parameter int VW  = 20,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          eof,
  input  logic [VW-1:0] m_00,
  input  logic [DW-1:0] m_01,
  input  logic [DW-1:0] m_10,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [VW-1:0] div_divisor,
  input  logic [DW-1:0] div_quotient,
  input  logic          div_qv,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y,
  output logic          valid,
  output logic          empty,
  output logic          overrun,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START_X = 3'd1,
    WAIT_X  = 3'd2,
    START_Y = 3'd3,
    WAIT_Y  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic          pend_full;
  logic [VW-1:0] pend_m00;
  logic [DW-1:0] pend_m01;
  logic [DW-1:0] pend_m10;

  // div_divisor doubles as the area shadow and div_dividend holds the x moment
  // shadow until the x division returns; the y moment waits in sh_m10.
  logic [DW-1:0] sh_m10;
  logic [DW-1:0] x_pend;

  logic          cap;
  logic [VW-1:0] cap_m00;
  logic [DW-1:0] cap_m01;
  logic [DW-1:0] cap_m10;
  logic          waiting;
  logic          timeout;

  // A live eof always wins over the pending slot; the slot is then dropped.
  assign cap     = (state == IDLE) && (eof || pend_full);
  assign cap_m00 = eof ? m_00 : pend_m00;
  assign cap_m01 = eof ? m_01 : pend_m01;
  assign cap_m10 = eof ? m_10 : pend_m10;
  assign waiting = (state == WAIT_X) || (state == WAIT_Y);

  assign div_start = (state == START_X) || (state == START_Y);
  assign valid     = (state == DONE);

`ifdef CENTROID_DIV_WATCHDOG_EN
  localparam int WDW = $clog2(TMO + 1);
  logic [WDW-1:0] wd_cnt;

  // Restarts from zero on every entry to a wait state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (waiting) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign timeout = waiting && !div_qv && (wd_cnt == WDW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= timeout;
    end
  end
`else
  // TMO only sizes the watchdog, which is absent in this build.
  logic tmo_unused;
  assign tmo_unused = (TMO > 0);
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cap) begin
          state_nxt = (cap_m00 == '0) ? DONE : START_X;
        end
      end
      START_X: state_nxt = WAIT_X;
      WAIT_X: begin
        if (div_qv) begin
          state_nxt = START_Y;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      START_Y: state_nxt = WAIT_Y;
      WAIT_Y: begin
        if (div_qv) begin
          state_nxt = DONE;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_full    <= 1'b0;
      pend_m00     <= '0;
      pend_m01     <= '0;
      pend_m10     <= '0;
      sh_m10       <= '0;
      x_pend       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      x            <= '0;
      y            <= '0;
      empty        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state <= state_nxt;

      // Any eof that finds the slot full displaces it: overwritten when busy,
      // discarded in favour of the live eof when idle.
      overrun <= eof && pend_full;

      if (state != IDLE) begin
        if (eof) begin
          pend_full <= 1'b1;
          pend_m00  <= m_00;
          pend_m01  <= m_01;
          pend_m10  <= m_10;
        end
      end else begin
        pend_full <= 1'b0;
      end

      if (cap) begin
        div_divisor  <= cap_m00;
        div_dividend <= cap_m01;
        sh_m10       <= cap_m10;
        // Zero area skips the divider; empty is visible with the valid pulse.
        if (cap_m00 == '0) begin
          empty <= 1'b1;
        end
      end

      if ((state == WAIT_X) && div_qv) begin
        x_pend       <= div_quotient;
        div_dividend <= sh_m10;
      end

      // x and y change only here, so they are published together with valid.
      if ((state == WAIT_Y) && div_qv) begin
        x     <= x_pend;
        y     <= div_quotient;
        empty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_centroid_div_sched.sv
// tb/tb_centroid_div_sched.sv - self-checking bench for centroid_div_sched
module tb_centroid_div_sched;
  localparam int DW  = 32;
  localparam int VW  = 20;
  localparam int TMO = 64;
  localparam int N   = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          eof = 1'b0;
  logic [VW-1:0] m_00 = '0;
  logic [DW-1:0] m_01 = '0;
  logic [DW-1:0] m_10 = '0;
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [VW-1:0] div_divisor;
  logic [DW-1:0] div_quotient = '0;
  logic          div_qv = 1'b0;
  logic [DW-1:0] x, y;
  logic          valid, empty, overrun, err;

  centroid_div_sched #(.DW(DW), .VW(VW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .eof(eof), .m_00(m_00), .m_01(m_01), .m_10(m_10),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_qv(div_qv),
    .x(x), .y(y), .valid(valid), .empty(empty), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Divider stand-in: answers each div_start after L cycles.
  int            L = 4;
  bit            div_en = 1'b1;
  int            due = -1;
  logic [DW-1:0] q = '0;

  // Frame-level reference: when the scheduler is free, what each frame must
  // produce and at which cycle, derived from the latency rules.
  int            free = 0;
  bit            pend = 1'b0;
  logic [VW-1:0] p00;
  logic [DW-1:0] p01, p10;
  bit            e_valid[N], e_ovr[N], e_err[N], e_ds[N], e_rst[N], e_upd[N], e_xy[N], e_em[N];
  logic [DW-1:0] e_x[N], e_y[N], e_dd[N];
  logic [VW-1:0] e_dv[N];

  task automatic start_frame(input int t, input logic [VW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    if (a == '0) begin
      e_valid[t+1] = 1'b1; e_upd[t+1] = 1'b1; e_xy[t+1] = 1'b0; e_em[t+1] = 1'b1;
      free = t + 2;
    end else begin
      e_ds[t+1] = 1'b1; e_dd[t+1] = b; e_dv[t+1] = a;
      if (div_en) begin
        e_ds[t+2+L] = 1'b1; e_dd[t+2+L] = c; e_dv[t+2+L] = a;
        e_valid[t+3+2*L] = 1'b1; e_upd[t+3+2*L] = 1'b1; e_xy[t+3+2*L] = 1'b1;
        e_x[t+3+2*L] = b / DW'(a); e_y[t+3+2*L] = c / DW'(a); e_em[t+3+2*L] = 1'b0;
        free = t + 4 + 2*L;
      end else begin
`ifdef CENTROID_DIV_WATCHDOG_EN
        e_err[t+2+TMO] = 1'b1;
        free = t + 2 + TMO;
`else
        free = N;
`endif
      end
    end
  endtask

  task automatic model(input int t, input bit r, input bit e, input logic [VW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    if (!r) begin
      for (int i = t + 1; i < N; i++) begin
        e_valid[i] = 0; e_ovr[i] = 0; e_err[i] = 0; e_ds[i] = 0; e_rst[i] = 0; e_upd[i] = 0;
      end
      e_rst[t+1] = 1'b1;
      pend = 1'b0;
      free = t + 1;
    end else if (t >= free) begin
      if (e) begin
        if (pend) e_ovr[t+1] = 1'b1;
        pend = 1'b0;
        start_frame(t, a, b, c);
      end else if (pend) begin
        pend = 1'b0;
        start_frame(t, p00, p01, p10);
      end
    end else if (e) begin
      if (pend) e_ovr[t+1] = 1'b1;
      pend = 1'b1; p00 = a; p01 = b; p10 = c;
    end
  endtask

  task automatic step(input bit e = 0, input logic [VW-1:0] a = 0, input logic [DW-1:0] b = 0,
                      input logic [DW-1:0] c = 0, input bit r = 1, input bit stray = 0);
    @(posedge clk); #1;
    if (cyc >= N - 200) begin
      $display("FAIL cycle_budget cyc=%0d actual=%0d required<%0d", cyc, cyc, N - 200);
      $fatal(1);
    end
    rst_n = r; eof = e; m_00 = a; m_01 = b; m_10 = c;
    if (!r) due = -1;
    div_qv = (cyc == due) || stray;
    div_quotient = div_qv ? q : DW'($urandom);
    model(cyc, r, e, a, b, c);
  endtask

  task automatic drain();
    int k = 0;
    while ((cyc < free || pend) && k < 500) begin
      step();
      k++;
    end
    chk("drain_bound", 64'(k < 500), 64'd1);
    step(); step();
  endtask

  // Per-cycle compare against the reference plus monitor counters.
  logic [DW-1:0] cx = '0, cy = '0;
  bit            ce = 1'b0;
  int            n_ds = 0, n_val = 0, n_ovr = 0, last_err = -1;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      if (e_rst[cyc]) begin cx = '0; cy = '0; ce = 1'b0; end
      if (e_upd[cyc]) begin
        if (e_xy[cyc]) begin cx = e_x[cyc]; cy = e_y[cyc]; end
        ce = e_em[cyc];
      end
      chk("valid", valid, e_valid[cyc]);
      chk("x", x, cx);
      chk("y", y, cy);
      chk("empty", empty, ce);
      chk("overrun", overrun, e_ovr[cyc]);
      chk("err", err, e_err[cyc]);
      chk("div_start", div_start, e_ds[cyc]);
      if (e_ds[cyc]) begin
        chk("div_dividend", div_dividend, e_dd[cyc]);
        chk("div_divisor", div_divisor, e_dv[cyc]);
      end
      if (div_start === 1'b1) n_ds++;
      if (valid === 1'b1) n_val++;
      if (overrun === 1'b1) n_ovr++;
      if (err === 1'b1) last_err = cyc;
      if (div_start === 1'b1 && div_en) begin
        due = cyc + L;
        q = (div_divisor != '0) ? div_dividend / DW'(div_divisor) : '1;
      end
    end
  end

  initial begin
    int ds0, v0, o0, t0;
    bit e;
    logic [VW-1:0] a;

    step(.r(0)); step(.r(0));
    chk("reset_x", x, 0);
    chk("reset_valid", valid, 0);
    chk("reset_div_start", div_start, 0);

    // 6400/100, 3200/100 with a 36-cycle divider
    L = 36; ds0 = n_ds; v0 = n_val;
    step(1, 100, 6400, 3200);
    drain();
    chk("f1_div_starts", n_ds - ds0, 2);
    chk("f1_x", x, 64);
    chk("f1_y", y, 32);
    chk("f1_valid_pulses", n_val - v0, 1);
    chk("f1_empty", empty, 0);

    // zero area keeps x/y, sets empty
    ds0 = n_ds; v0 = n_val;
    step(1, 0, 123, 456);
    drain();
    chk("f0_div_starts", n_ds - ds0, 0);
    chk("f0_valid_pulses", n_val - v0, 1);
    chk("f0_empty", empty, 1);
    chk("f0_x", x, 64);
    chk("f0_y", y, 32);

    // second eof in WAIT_X pends, third overwrites it
    L = 10; o0 = n_ovr; v0 = n_val;
    step(1, 4, 400, 80);
    repeat (4) step();
    step(1, 8, 800, 88);
    chk("pend_no_overrun", n_ovr - o0, 0);
    step(); step();
    step(1, 10, 500, 70);
    drain();
    chk("pend_overrun", n_ovr - o0, 1);
    chk("pend_x", x, 50);
    chk("pend_y", y, 7);
    chk("pend_valid_pulses", n_val - v0, 2);

    // eof in IDLE while the slot is full
    o0 = n_ovr;
    step(1, 0, 1, 1);
    step(1, 3, 30, 60);
    step(1, 5, 50, 100);
    drain();
    chk("idle_full_overrun", n_ovr - o0, 1);
    chk("idle_full_x", x, 10);
    chk("idle_full_y", y, 20);

    // stray div_qv while idle
    v0 = n_val;
    step(.stray(1)); step(); step();
    chk("stray_valid", n_val - v0, 0);

    // reset during WAIT_Y, late div_qv ignored
    L = 10; v0 = n_val;
    step(1, 2, 20, 40);
    t0 = cyc;
    while (cyc < t0 + 13) step();
    step(.r(0));
    step();
    chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_valid", valid, 0);
    chk("rst_empty", empty, 0); chk("rst_div_start", div_start, 0);
    chk("rst_overrun", overrun, 0); chk("rst_err", err, 0);
    repeat (3) step();
    step(.stray(1));
    repeat (15) step();
    chk("rst_late_qv_valid", n_val - v0, 0);

`ifdef CENTROID_DIV_WATCHDOG_EN
    // divider never answers; a frame arriving meanwhile stays pending
    div_en = 1'b0; v0 = n_val;
    step(1, 5, 50, 50);
    t0 = cyc;
    repeat (9) step();
    step(1, 4, 40, 8);
    div_en = 1'b1;
    while (cyc < t0 + 2 + TMO) step();
    step();
    chk("wd_latency", last_err - (t0 + 2), TMO);
    chk("wd_no_valid", n_val - v0, 0);
    chk("wd_x_held", x, 0);
    drain();
    chk("wd_pend_x", x, 10);
    chk("wd_pend_y", y, 2);
`endif

    // randomized frames
    for (int r = 0; r < 10; r++) begin
      L = $urandom_range(1, 20);
      for (int i = 0; i < 40; i++) begin
        e = ($urandom_range(0, 5) == 0);
        a = ($urandom_range(0, 4) == 0) ? '0 : VW'($urandom_range(1, (1 << VW) - 1));
        step(e, a, $urandom, $urandom, ($urandom_range(0, 99) != 0));
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/centroid_div_sched.md
CENTROID_DIV_SCHED -- requirements
Module: centroid_div_sched

Interface
REQ-001 SHALL have parameter DW, default 32: moment (dividend) and quotient width.
REQ-002 SHALL have parameter VW, default 20: area (divisor) width.
REQ-003 SHALL have parameter TMO, default 64: divider watchdog limit in cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port eof, input, 1: end-of-frame pulse; moments valid in the same cycle.
REQ-007 SHALL have port m_00, input, VW: frame area.
REQ-008 SHALL have port m_01, input, DW: x moment.
REQ-009 SHALL have port m_10, input, DW: y moment.
REQ-010 SHALL have port div_start, output, 1: one-cycle start strobe to the shared divider.
REQ-011 SHALL have port div_dividend, output, DW: registered dividend to the divider.
REQ-012 SHALL have port div_divisor, output, VW: registered divisor to the divider.
REQ-013 SHALL have port div_quotient, input, DW: divider result.
REQ-014 SHALL have port div_qv, input, 1: divider result-valid pulse.
REQ-015 SHALL have ports x and y, output, DW each: centroid coordinates.
REQ-016 SHALL have port valid, output, 1: one-cycle pulse when x and y update.
REQ-017 SHALL have port empty, output, 1: set when the last frame had area 0.
REQ-018 SHALL have port overrun, output, 1: one-cycle pulse when a pending frame is dropped.
REQ-019 SHALL have port err, output, 1: one-cycle pulse on divider timeout.

Function
REQ-020 SHALL use one divider for both axes, with states IDLE, START_X, WAIT_X, START_Y, WAIT_Y, DONE.
REQ-021 SHALL, on eof in IDLE, capture m_00, m_01 and m_10 into shadow registers and go to START_X on the next cycle.
REQ-022 SHALL, when the captured m_00 is 0, go from capture to DONE without any div_start, hold x and y, and set empty to 1.
REQ-023 SHALL, in START_X, drive div_start=1 for exactly one cycle with dividend=m_01 shadow and divisor=m_00 shadow, then enter WAIT_X.
REQ-024 SHALL, in WAIT_X on div_qv, store div_quotient as the pending x and enter START_Y.
REQ-025 SHALL make START_Y and WAIT_Y behave as START_X and WAIT_X, using m_10 and storing y.
REQ-026 SHALL, in DONE, update x and y together, pulse valid for one cycle, write empty, and return to IDLE.
REQ-027 SHALL take 1 cycle from eof to div_start(x), and 1 cycle from each div_qv to the next action.
REQ-028 SHALL ignore div_qv outside the WAIT_X and WAIT_Y states.
REQ-029 SHALL, on eof outside IDLE, latch the moments into a one-deep pending slot.
REQ-030 SHALL, when the pending slot is already full, overwrite it with the newest eof and pulse overrun.
REQ-031 SHALL serve a full pending slot on the cycle after the return to IDLE, treated as a fresh eof.
REQ-032 SHALL, when eof arrives in IDLE while the pending slot is full, capture the new eof, clear the slot and pulse overrun.
REQ-033 SHALL keep x and y unchanged between valid pulses.

Reset
REQ-034 SHALL, while rst_n=0 at a clock edge, force state=IDLE and clear the pending slot and the shadow registers.
REQ-035 SHALL hold x, y, valid, empty, overrun, err and div_start at 0 during reset.
REQ-036 SHALL, on reset mid-operation, abandon the in-flight division and ignore any later div_qv.

Configuration
REQ-037 SHALL, with CENTROID_DIV_WATCHDOG_EN defined, count cycles spent in WAIT_X or WAIT_Y.
REQ-038 SHALL, on that count reaching TMO, pulse err, return to IDLE with x and y unchanged and no valid, and keep any pending slot.
REQ-039 SHALL, without CENTROID_DIV_WATCHDOG_EN, wait indefinitely for div_qv and tie err to 0.

Verification
REQ-040 SHALL cover: eof with m_01=6400, m_10=3200, m_00=100 and a 36-cycle divider model -> two div_start pulses, then x=64, y=32, valid for 1 cycle, empty=0.
REQ-041 SHALL cover: eof with m_00=0 -> no div_start, valid pulse, empty=1, and x and y keep their previous values 64 and 32.
REQ-042 SHALL cover: second eof during WAIT_X -> served after DONE with no overrun; a third eof before service -> overrun pulse, and the third frame's moments are used.
REQ-043 SHALL cover, with the macro defined: div_qv never asserted -> err pulse exactly 64 cycles after entering WAIT_X, state IDLE, no valid.
REQ-044 SHALL cover: rst_n low for 1 cycle during WAIT_Y -> all outputs 0, and a div_qv arriving 5 cycles later produces no valid.
